// File: rtl/seed_random_4_control_path.sv
// seed_random_4 control path: turns a level card request into one bounded
// SEND window on state_o per request assertion.
//
// Request protocol: req_card_state_cp is a level sampled on each rising edge
// of clk_cp_i. A sampled high level in IDLE opens one SEND window of
// SEND_CYCLES cycles. The window length is fixed once opened. The request must
// then be sampled low before another window can open.
`timescale 1ns/1ps

module seed_random_4_control_path #(
    parameter int SEND_CYCLES = 1,
    parameter int CNT_W       = 8
) (
    input  logic clk_cp_i,
    input  logic rst_cp_i,
    input  logic req_card_state_cp,
    output logic state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEND = 2'b01,
        ST_HOLD = 2'b10
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SEND_CYCLES - 1);

    state_e             state_q;
    state_e             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               send_q;
    logic               send_d;

    // Next-state and counter logic; unused encodings fall back to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_card_state_cp) begin
                    state_d = ST_SEND;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_SEND: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (req_card_state_cp) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (!req_card_state_cp) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        send_d = (state_d == ST_SEND);
    end

    // State, counter and output flop; reset clears all of them asynchronously.
    always_ff @(posedge clk_cp_i or posedge rst_cp_i) begin
        if (rst_cp_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            send_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            send_q  <= send_d;
        end
    end

    assign state_o = send_q;

endmodule

// File: tb/tb_seed_random_4_control_path.sv
// Bench for seed_random_4_control_path: one instance with SEND_CYCLES=1
// driven from a vector table, one with SEND_CYCLES=4 driven by hand-written
// sequences, both checked through expected-value queues.
`timescale 1ns/1ps

module tb_seed_random_4_control_path;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1;
    logic req_a = 1'bx;
    logic out_a;
    logic rst_b = 1'b1;
    logic req_b = 1'b0;
    logic out_b;

    seed_random_4_control_path #(.SEND_CYCLES(1), .CNT_W(8)) dut_a (
        .clk_cp_i          (clk),
        .rst_cp_i          (rst_a),
        .req_card_state_cp (req_a),
        .state_o           (out_a)
    );

    seed_random_4_control_path #(.SEND_CYCLES(4), .CNT_W(8)) dut_b (
        .clk_cp_i          (clk),
        .rst_cp_i          (rst_b),
        .req_card_state_cp (req_b),
        .state_o           (out_b)
    );

    // ---------------- scoreboard ----------------
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [0:0] exp_q_a[$];
    logic [0:0] exp_q_b[$];

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: state_o=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change on the falling edge; the result is sampled 1 ns after
    // the following rising edge.
    task automatic drive_a(input logic rst, input logic req, input logic exp, input string name);
        logic [0:0] e;
        @(negedge clk);
        rst_a = rst;
        req_a = req;
        exp_q_a.push_back(exp);
        @(posedge clk);
        #1;
        e = exp_q_a.pop_front();
        check(name, out_a, e[0]);
    endtask

    task automatic drive_b(input logic rst, input logic req, input logic exp, input string name);
        logic [0:0] e;
        @(negedge clk);
        rst_b = rst;
        req_b = req;
        exp_q_b.push_back(exp);
        @(posedge clk);
        #1;
        e = exp_q_b.pop_front();
        check(name, out_b, e[0]);
    endtask

    // ---------------- vector table for SEND_CYCLES=1 ----------------
    typedef struct packed {
        logic req;
        logic exp;
    } vec_t;

    vec_t tbl[$];

    function automatic void add_vec(input logic r, input logic e);
        vec_t v;
        v.req = r;
        v.exp = e;
        tbl.push_back(v);
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- main test ----------------
    initial begin
        // Request held high: one pulse, then HOLD, release back to IDLE.
        add_vec(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) add_vec(1'b1, 1'b0);
        add_vec(1'b0, 1'b0);
        add_vec(1'b0, 1'b0);
        // Three 50 ns / 50 ns request pulses: one single-cycle window each.
        for (int p = 0; p < 3; p++) begin
            add_vec(1'b1, 1'b1);
            for (int i = 0; i < 4; i++) add_vec(1'b1, 1'b0);
            for (int i = 0; i < 5; i++) add_vec(1'b0, 1'b0);
        end
        // One-cycle request pulse still gives a full window.
        add_vec(1'b1, 1'b1);
        add_vec(1'b0, 1'b0);
        add_vec(1'b0, 1'b0);
        // Release from HOLD, then a new request on the very next edge.
        add_vec(1'b1, 1'b1);
        add_vec(1'b1, 1'b0);
        add_vec(1'b0, 1'b0);
        add_vec(1'b1, 1'b1);
        add_vec(1'b0, 1'b0);

        // Reset with request unknown, checked between clock edges.
        #1;
        check("a_reset_t1", out_a, 1'b0);
        check("b_reset_t1", out_b, 1'b0);
        #11;
        check("a_reset_t12", out_a, 1'b0);
        #10;
        check("a_reset_t22", out_a, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive_a(1'b0, tbl[i].req, tbl[i].exp, $sformatf("a_vec%0d", i));
        end

        // Pulse entirely between two rising edges is never seen.
        @(posedge clk);
        #2 req_a = 1'b1;
        #2 req_a = 1'b0;
        drive_a(1'b0, 1'b0, 1'b0, "a_missed_pulse0");
        drive_a(1'b0, 1'b0, 1'b0, "a_missed_pulse1");

        // Reset in the middle of a SEND cycle drops state_o without a clock.
        drive_a(1'b0, 1'b1, 1'b1, "a_pre_async");
        #2 rst_a = 1'b1;
        #1 check("a_async_reset", out_a, 1'b0);
        drive_a(1'b1, 1'b0, 1'b0, "a_in_reset");
        drive_a(1'b0, 1'b0, 1'b0, "a_post_reset0");
        drive_a(1'b0, 1'b0, 1'b0, "a_post_reset1");

        // SEND_CYCLES=4: single-cycle request gives a four-cycle window.
        drive_b(1'b0, 1'b1, 1'b1, "b_win0");
        drive_b(1'b0, 1'b0, 1'b1, "b_win1");
        drive_b(1'b0, 1'b0, 1'b1, "b_win2");
        drive_b(1'b0, 1'b0, 1'b1, "b_win3");
        drive_b(1'b0, 1'b0, 1'b0, "b_win_end0");
        drive_b(1'b0, 1'b0, 1'b0, "b_win_end1");

        // Reset after two SEND cycles; the window is not resumed.
        drive_b(1'b0, 1'b1, 1'b1, "b_mid0");
        drive_b(1'b0, 1'b0, 1'b1, "b_mid1");
        #2 rst_b = 1'b1;
        #1 check("b_async_reset", out_b, 1'b0);
        drive_b(1'b1, 1'b0, 1'b0, "b_in_reset");
        for (int i = 0; i < 4; i++) begin
            drive_b(1'b0, 1'b0, 1'b0, $sformatf("b_no_resume%0d", i));
        end

        // Reset released with request already high: window on first edge,
        // then HOLD while request stays high.
        drive_b(1'b1, 1'b1, 1'b0, "b_rst_req_hi");
        drive_b(1'b0, 1'b1, 1'b1, "b_rel0");
        for (int i = 1; i < 4; i++) begin
            drive_b(1'b0, 1'b1, 1'b1, $sformatf("b_rel%0d", i));
        end
        for (int i = 0; i < 4; i++) begin
            drive_b(1'b0, 1'b1, 1'b0, $sformatf("b_hold%0d", i));
        end
        drive_b(1'b0, 1'b0, 1'b0, "b_hold_release");
        drive_b(1'b0, 1'b1, 1'b1, "b_new_req0");
        drive_b(1'b0, 1'b1, 1'b1, "b_new_req1");
        drive_b(1'b0, 1'b0, 1'b1, "b_new_req2");
        drive_b(1'b0, 1'b0, 1'b1, "b_new_req3");
        drive_b(1'b0, 1'b0, 1'b0, "b_new_req_end");

        if (exp_q_a.size() != 0 || exp_q_b.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: left a=%0d b=%0d expected 0", exp_q_a.size(), exp_q_b.size());
        end

        // ---------------- final report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
